// File: rtl/rgb_stream_rx.sv
// Receive side of the serial RGB stream feeding the K-means core: assembles
// R,G,B byte triplets into indexed 24-bit pixels and buffers them in a FWFT FIFO.
module rgb_stream_rx #(
    parameter int NUM_PIXELS = 4096,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 19
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [7:0]       Sin,
    output logic [23:0]      pix_rgb,
    output logic [CNT_W-1:0] pix_index,
    output logic             pix_last,
    output logic             pix_valid,
    input  logic             pix_ready,
    output logic             busy,
    output logic             overflow,
    output logic             Strb
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int OCC_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_PIXELS - 1);
    localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        DRAIN,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [1:0]       phase;
    logic [CNT_W-1:0] count;
    logic [7:0]       r_byte;
    logic [7:0]       g_byte;

    logic [23:0]      rgb_mem [FIFO_DEPTH];
    logic [CNT_W-1:0] idx_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [OCC_W-1:0] occ;

    logic push;
    logic pop;
    logic full;
    logic wr_en;
    logic drop;

    // A full FIFO can still accept a pixel when the head leaves on the same edge.
    assign push  = (state == RECV) && (phase == 2'd2);
    assign pop   = pix_valid && pix_ready;
    assign full  = (occ == FULL_OCC);
    assign wr_en = push && (!full || pop);
    assign drop  = push && full && !pop;

    assign pix_valid = (occ != '0);
    assign pix_rgb   = pix_valid ? rgb_mem[rd_ptr] : '0;
    assign pix_index = pix_valid ? idx_mem[rd_ptr] : '0;
    assign pix_last  = pix_valid && (idx_mem[rd_ptr] == LAST_IDX);
    assign busy      = (state != IDLE);
    assign Strb      = (state == DONE);

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (Start) state_next = RECV;
            RECV:    if (push && (count == LAST_IDX)) state_next = DRAIN;
            DRAIN:   if (occ == '0) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Byte assembly: phase 0 holds R, phase 1 holds G, phase 2 completes the pixel.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            phase    <= 2'd0;
            count    <= '0;
            r_byte   <= 8'd0;
            g_byte   <= 8'd0;
            overflow <= 1'b0;
        end else if ((state == IDLE) && Start) begin
            phase    <= 2'd0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (state == RECV) begin
            case (phase)
                2'd0: begin
                    r_byte <= Sin;
                    phase  <= 2'd1;
                end
                2'd1: begin
                    g_byte <= Sin;
                    phase  <= 2'd2;
                end
                default: begin
                    phase <= 2'd0;
                    count <= count + CNT_W'(1);
                end
            endcase
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            rgb_mem[wr_ptr] <= {r_byte, g_byte, Sin};
            idx_mem[wr_ptr] <= count;
        end
    end

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({wr_en, pop})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: occ <= occ;
            endcase
        end
    end

endmodule

// File: tb/tb_rgb_stream_rx.sv
// Self-checking bench for rgb_stream_rx: random frames against a queue-based
// model of the pixel buffer, plus directed reset, overflow and restart scenarios.
module tb_rgb_stream_rx;
    localparam int N     = 6;
    localparam int DEPTH = 4;
    localparam int CW    = 19;

    logic          clk = 1'b0;
    logic          Reset;
    logic          Start;
    logic [7:0]    Sin;
    logic          pix_ready;
    logic [23:0]   pix_rgb;
    logic [CW-1:0] pix_index;
    logic          pix_last;
    logic          pix_valid;
    logic          busy;
    logic          overflow;
    logic          Strb;

    rgb_stream_rx #(
        .NUM_PIXELS(N),
        .FIFO_DEPTH(DEPTH),
        .CNT_W(CW)
    ) dut (
        .clk(clk),
        .Reset(Reset),
        .Start(Start),
        .Sin(Sin),
        .pix_rgb(pix_rgb),
        .pix_index(pix_index),
        .pix_last(pix_last),
        .pix_valid(pix_valid),
        .pix_ready(pix_ready),
        .busy(busy),
        .overflow(overflow),
        .Strb(Strb)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [23:0]   rgb;
        logic [CW-1:0] idx;
        logic          last;
    } pix_t;

    int compared   = 0;
    int mismatched = 0;

    pix_t got_q[$];
    pix_t exp_q[$];
    int   r_view_err;
    int   r_strb_count;
    int   r_strb_edge;
    int   r_last_pop_edge;
    bit   r_dropped;
    bit   r_timeout;
    logic r_final_ovf;
    logic r_ovf_after_start;
    logic r_busy_after_strb;
    logic r_end_busy;
    logic r_restarted;

    // Runs one frame; edge 0 is the Start edge, byte b is sampled at edge b+1.
    // The model is a bounded queue: pops first, then the pixel push (dropped when full).
    task automatic run_frame(input logic [7:0] data[], input bit rdy[], input int start_pulse_at,
                             input bit start_in_done, input bit hold_start, input bit already_started);
        pix_t q[$];
        pix_t p;
        pix_t a;
        int   bidx;
        int   e;
        bit   in_recv;
        bit   pop_m;
        bit   prev_strb;
        got_q.delete();
        exp_q.delete();
        r_view_err = 0;
        r_strb_count = 0;
        r_strb_edge = -1;
        r_last_pop_edge = -1;
        r_dropped = 0;
        r_timeout = 1;
        r_busy_after_strb = 1'bx;
        r_end_busy = 1'bx;
        r_restarted = 1'b0;
        r_ovf_after_start = 1'bx;
        bidx = 0;
        prev_strb = 0;
        in_recv = already_started;
        e = already_started ? 1 : 0;
        for (int it = 0; it < 3 * N + 200; it++) begin
            if (!already_started && e == 0) begin
                Start = 1'b1;
            end else begin
                Start = hold_start || (in_recv && bidx == start_pulse_at) || (start_in_done && prev_strb);
            end
            Sin = in_recv ? data[bidx] : 8'($urandom);
            pix_ready = (e < rdy.size()) ? rdy[e] : 1'b1;
            pop_m = (q.size() > 0) && pix_ready;
            if (pix_valid && pix_ready) begin
                a.rgb = pix_rgb;
                a.idx = pix_index;
                a.last = pix_last;
                got_q.push_back(a);
            end
            @(posedge clk);
            if (pop_m) begin
                exp_q.push_back(q.pop_front());
                r_last_pop_edge = e;
            end
            if (!already_started && e == 0) begin
                in_recv = 1;
            end else if (in_recv) begin
                if (bidx % 3 == 2) begin
                    p.rgb = {data[bidx-2], data[bidx-1], data[bidx]};
                    p.idx = CW'(bidx / 3);
                    p.last = (bidx / 3 == N - 1);
                    if (q.size() >= DEPTH) r_dropped = 1;
                    else q.push_back(p);
                end
                bidx++;
                if (bidx == 3 * N) in_recv = 0;
            end
            #1;
            if (it == 0) r_ovf_after_start = overflow;
            if (pix_valid !== (q.size() > 0)) begin
                r_view_err++;
            end else if (q.size() > 0) begin
                if (pix_rgb !== q[0].rgb || pix_index !== q[0].idx || pix_last !== q[0].last) r_view_err++;
            end
            if (Strb === 1'b1) begin
                r_strb_count++;
                if (r_strb_edge < 0) r_strb_edge = e;
            end
            if (r_strb_edge >= 0 && e == r_strb_edge + 1) r_busy_after_strb = busy;
            prev_strb = (Strb === 1'b1);
            if (r_strb_edge >= 0 && hold_start && e == r_strb_edge + 2) begin
                r_restarted = busy;
                r_timeout = 0;
                break;
            end
            if (r_strb_edge >= 0 && !hold_start && e == r_strb_edge + 3) begin
                r_end_busy = busy;
                r_timeout = 0;
                break;
            end
            e++;
        end
        r_final_ovf = overflow;
        Start = 1'b0;
    endtask

    task automatic test_reset();
        logic [54:0] all_out;
        Reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            Start = 1'($urandom);
            Sin = 8'($urandom);
            pix_ready = 1'($urandom);
            @(posedge clk);
            #1;
            all_out = {pix_rgb, pix_index, pix_last, pix_valid, busy, overflow, Strb};
            compared++;
            if (all_out !== '0) begin
                mismatched++;
                $display("[TB] FAIL reset_outputs: got %h expected 0", all_out);
            end
        end
        Start = 1'b0;
        pix_ready = 1'b1;
        @(negedge clk);
        Reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            compared++;
            if (busy !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL idle_busy: got %b expected 0", busy);
            end
            compared++;
            if (pix_valid !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL idle_valid: got %b expected 0", pix_valid);
            end
        end
    endtask

    task automatic test_nominal();
        logic [7:0]  data[];
        bit          rdy[];
        logic [23:0] want;
        data = new[3 * N];
        for (int i = 0; i < 3 * N; i++) data[i] = 8'(i + 1);
        run_frame(data, rdy, -1, 0, 0, 0);
        compared++;
        if (got_q.size() != N) begin
            mismatched++;
            $display("[TB] FAIL nominal_count: got %0d expected %0d", got_q.size(), N);
        end
        for (int k = 0; k < N && k < got_q.size(); k++) begin
            want = {8'(3 * k + 1), 8'(3 * k + 2), 8'(3 * k + 3)};
            compared++;
            if (got_q[k].rgb !== want || got_q[k].idx !== CW'(k) || got_q[k].last !== (k == N - 1)) begin
                mismatched++;
                $display("[TB] FAIL nominal_pixel%0d: got %h/%0d/%b expected %h/%0d/%b",
                         k, got_q[k].rgb, got_q[k].idx, got_q[k].last, want, k, (k == N - 1));
            end
        end
        compared++;
        if (r_view_err != 0 || r_timeout) begin
            mismatched++;
            $display("[TB] FAIL nominal_view: got %0d errors timeout=%0b expected 0", r_view_err, r_timeout);
        end
        compared++;
        if (r_strb_count != 1 || r_strb_edge != 3 * N + 2) begin
            mismatched++;
            $display("[TB] FAIL nominal_strb: got count %0d at edge %0d expected 1 at %0d",
                     r_strb_count, r_strb_edge, 3 * N + 2);
        end
        compared++;
        if (r_final_ovf !== 1'b0 || r_busy_after_strb !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL nominal_flags: got ovf=%b busy=%b expected 0/0", r_final_ovf, r_busy_after_strb);
        end
    endtask

    task automatic test_overflow();
        logic [7:0]  data[];
        bit          rdy[];
        logic [23:0] want;
        data = new[3 * N];
        for (int i = 0; i < 3 * N; i++) data[i] = 8'($urandom);
        rdy = new[3 * N + 5];
        run_frame(data, rdy, -1, 0, 0, 0);
        compared++;
        if (got_q.size() != DEPTH) begin
            mismatched++;
            $display("[TB] FAIL ovf_count: got %0d expected %0d", got_q.size(), DEPTH);
        end
        for (int k = 0; k < DEPTH && k < got_q.size(); k++) begin
            want = {data[3*k], data[3*k+1], data[3*k+2]};
            compared++;
            if (got_q[k].rgb !== want || got_q[k].idx !== CW'(k) || got_q[k].last !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL ovf_pixel%0d: got %h/%0d/%b expected %h/%0d/0",
                         k, got_q[k].rgb, got_q[k].idx, got_q[k].last, want, k);
            end
        end
        compared++;
        if (r_final_ovf !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL ovf_sticky: got %b expected 1", r_final_ovf);
        end
        compared++;
        if (r_strb_count != 1 || r_strb_edge != r_last_pop_edge + 1 || r_timeout) begin
            mismatched++;
            $display("[TB] FAIL ovf_strb: got count %0d edge %0d expected 1 at %0d",
                     r_strb_count, r_strb_edge, r_last_pop_edge + 1);
        end
        compared++;
        if (r_view_err != 0) begin
            mismatched++;
            $display("[TB] FAIL ovf_view: got %0d errors expected 0", r_view_err);
        end
        rdy.delete();
        run_frame(data, rdy, -1, 0, 0, 0);
        compared++;
        if (r_ovf_after_start !== 1'b0 || r_final_ovf !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL ovf_clear: got %b/%b expected 0/0", r_ovf_after_start, r_final_ovf);
        end
    endtask

    task automatic test_full_simul_pop();
        logic [7:0] data[];
        bit         rdy[];
        data = new[3 * N];
        for (int i = 0; i < 3 * N; i++) data[i] = 8'($urandom);
        rdy = new[19];
        rdy[15] = 1'b1;
        rdy[18] = 1'b1;
        run_frame(data, rdy, -1, 0, 0, 0);
        compared++;
        if (got_q.size() != N || r_final_ovf !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL fullpop_nodrop: got %0d pixels ovf=%b expected %0d ovf=0",
                     got_q.size(), r_final_ovf, N);
        end
        for (int k = 0; k < got_q.size(); k++) begin
            compared++;
            if (got_q[k].idx !== CW'(k) || got_q[k].rgb !== {data[3*k], data[3*k+1], data[3*k+2]}) begin
                mismatched++;
                $display("[TB] FAIL fullpop_order%0d: got %h/%0d expected %h/%0d", k, got_q[k].rgb,
                         got_q[k].idx, {data[3*k], data[3*k+1], data[3*k+2]}, k);
            end
        end
        compared++;
        if (r_view_err != 0 || r_timeout) begin
            mismatched++;
            $display("[TB] FAIL fullpop_view: got %0d errors timeout=%0b expected 0", r_view_err, r_timeout);
        end
    endtask

    task automatic test_ignored_start();
        logic [7:0] data[];
        bit         rdy[];
        data = new[3 * N];
        for (int i = 0; i < 3 * N; i++) data[i] = 8'($urandom);
        run_frame(data, rdy, 5, 1, 0, 0);
        compared++;
        if (got_q.size() != N) begin
            mismatched++;
            $display("[TB] FAIL ignstart_count: got %0d expected %0d", got_q.size(), N);
        end
        for (int k = 0; k < got_q.size(); k++) begin
            compared++;
            if (got_q[k].idx !== CW'(k) || got_q[k].rgb !== {data[3*k], data[3*k+1], data[3*k+2]}) begin
                mismatched++;
                $display("[TB] FAIL ignstart_pixel%0d: got %h/%0d expected %h/%0d", k, got_q[k].rgb,
                         got_q[k].idx, {data[3*k], data[3*k+1], data[3*k+2]}, k);
            end
        end
        compared++;
        if (r_strb_count != 1 || r_busy_after_strb !== 1'b0 || r_end_busy !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL ignstart_strb: got count %0d busy %b/%b expected 1 0/0",
                     r_strb_count, r_busy_after_strb, r_end_busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] data_a[];
        logic [7:0] data_b[];
        bit         rdy[];
        data_a = new[3 * N];
        data_b = new[3 * N];
        for (int i = 0; i < 3 * N; i++) begin
            data_a[i] = 8'($urandom);
            data_b[i] = 8'($urandom);
        end
        run_frame(data_a, rdy, -1, 0, 1, 0);
        compared++;
        if (r_restarted !== 1'b1 || r_busy_after_strb !== 1'b0 || r_strb_count != 1) begin
            mismatched++;
            $display("[TB] FAIL b2b_restart: got busy %b->%b strb %0d expected 0->1 strb 1",
                     r_busy_after_strb, r_restarted, r_strb_count);
        end
        compared++;
        if (got_q.size() != N || got_q != exp_q || r_view_err != 0) begin
            mismatched++;
            $display("[TB] FAIL b2b_frame_a: got %0d pixels %0d view errors expected %0d and 0",
                     got_q.size(), r_view_err, N);
        end
        run_frame(data_b, rdy, -1, 0, 0, 1);
        compared++;
        if (got_q.size() != N || got_q != exp_q || r_view_err != 0 || r_strb_count != 1) begin
            mismatched++;
            $display("[TB] FAIL b2b_frame_b: got %0d pixels %0d view errors strb %0d expected %0d 0 1",
                     got_q.size(), r_view_err, r_strb_count, N);
        end
    endtask

    task automatic test_reset_midframe();
        logic [7:0]  data[];
        bit          rdy[];
        logic [54:0] all_out;
        pix_ready = 1'b0;
        Start = 1'b1;
        @(posedge clk);
        #1;
        Start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            Sin = 8'($urandom);
            @(posedge clk);
            #1;
        end
        compared++;
        if (pix_valid !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL midreset_pre_valid: got %b expected 1", pix_valid);
        end
        #2;
        Reset = 1'b0;
        #1;
        all_out = {pix_rgb, pix_index, pix_last, pix_valid, busy, overflow, Strb};
        compared++;
        if (all_out !== '0) begin
            mismatched++;
            $display("[TB] FAIL midreset_async: got %h expected 0", all_out);
        end
        @(negedge clk);
        Reset = 1'b1;
        data = new[3 * N];
        for (int i = 0; i < 3 * N; i++) data[i] = 8'($urandom);
        data[0] = 8'hAA;
        data[1] = 8'hBB;
        data[2] = 8'hCC;
        run_frame(data, rdy, -1, 0, 0, 0);
        compared++;
        if (got_q.size() != N || got_q[0].rgb !== 24'hAABBCC || got_q[0].idx !== '0) begin
            mismatched++;
            $display("[TB] FAIL midreset_first: got %0d pixels first %h/%0d expected %0d aabbcc/0",
                     got_q.size(), got_q[0].rgb, got_q[0].idx, N);
        end
    endtask

    task automatic test_random();
        logic [7:0] data[];
        bit         rdy[];
        for (int f = 0; f < 4; f++) begin
            data = new[3 * N];
            for (int i = 0; i < 3 * N; i++) data[i] = 8'($urandom);
            rdy = new[3 * N + 12];
            for (int i = 0; i < rdy.size(); i++) rdy[i] = (f % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            run_frame(data, rdy, -1, 0, 0, 0);
            compared++;
            if (got_q.size() != exp_q.size() || got_q != exp_q) begin
                mismatched++;
                $display("[TB] FAIL random%0d_stream: got %0d pixels expected %0d (or content differs)",
                         f, got_q.size(), exp_q.size());
            end
            compared++;
            if (r_final_ovf !== logic'(r_dropped)) begin
                mismatched++;
                $display("[TB] FAIL random%0d_ovf: got %b expected %b", f, r_final_ovf, r_dropped);
            end
            compared++;
            if (r_strb_count != 1 || r_strb_edge != r_last_pop_edge + 1 || r_view_err != 0 || r_timeout) begin
                mismatched++;
                $display("[TB] FAIL random%0d_timing: got strb %0d@%0d view errors %0d expected 1@%0d and 0",
                         f, r_strb_count, r_strb_edge, r_view_err, r_last_pop_edge + 1);
            end
        end
    endtask

    initial begin
        Reset = 1'b0;
        Start = 1'b0;
        Sin = 8'd0;
        pix_ready = 1'b1;
        test_reset();
        test_nominal();
        test_overflow();
        test_full_simul_pop();
        test_ignored_start();
        test_back_to_back();
        test_reset_midframe();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
